// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPERATE = 2'd1,
    DONE    = 2'd2
  } mult_state_t;

  localparam int DEFAULT_XLEN = 16;

endpackage

// File: rtl/seq_mult_if.sv
// Operand/result handshake bundle between the issuing controller and seq_mult.
interface seq_mult_if #(
  parameter int XLEN = mult_pkg::DEFAULT_XLEN
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   a_i;
  logic [XLEN-1:0]   b_i;
  logic              signed_i;
  logic              out_valid;
  logic              out_ready;
  logic [2*XLEN-1:0] product_o;
  logic              busy_o;

  modport master (
    output in_valid, a_i, b_i, signed_i, out_ready,
    input  in_ready, out_valid, product_o, busy_o
  );

  modport slave (
    input  in_valid, a_i, b_i, signed_i, out_ready,
    output in_ready, out_valid, product_o, busy_o
  );
endinterface

// File: rtl/mult_shift_add_dp.sv
// Shift-add datapath: magnitude load, per-cycle add/shift, and sign-corrected result.
module mult_shift_add_dp
  import mult_pkg::*;
#(
  parameter int XLEN       = DEFAULT_XLEN,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  input  logic              signed_i,
  output logic              last_o,
  output logic [2*XLEN-1:0] result_o
);
  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;

  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] sum;

  // The most negative input negates to itself, which reads correctly as unsigned.
  assign a_mag = (signed_i && a_i[XLEN-1]) ? -a_i : a_i;
  assign b_mag = (signed_i && b_i[XLEN-1]) ? -b_i : b_i;

  assign sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign result_o = neg_q ? -sum : sum;
  assign last_o   = (cnt_q == CW'(XLEN-1)) ||
                    (EARLY_TERM && (mplier_q[XLEN-1:1] == '0));

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    if (load_i) begin
      mcand_d  = {{XLEN{1'b0}}, a_mag};
      mplier_d = b_mag;
      acc_d    = '0;
      cnt_d    = '0;
      neg_d    = signed_i & (a_i[XLEN-1] ^ b_i[XLEN-1]);
    end else if (step_i) begin
      acc_d    = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: rtl/seq_mult.sv
// Sequential multiplier top: IDLE/OPERATE/DONE control and both handshakes.
module seq_mult
  import mult_pkg::*;
#(
  parameter int XLEN       = DEFAULT_XLEN,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  seq_mult_if.slave bus
);
  mult_state_t       state_q, state_d;
  logic [2*XLEN-1:0] product_q, product_d;
  logic              accept;
  logic              step;
  logic              last;
  logic [2*XLEN-1:0] result;

  // in_ready is gated by reset so nothing is accepted during the reset cycle.
  assign bus.in_ready  = (state_q == IDLE) && !reset;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy_o    = (state_q == OPERATE) || (state_q == DONE);
  assign bus.product_o = product_q;
  assign accept        = bus.in_valid && bus.in_ready;

  mult_shift_add_dp #(
    .XLEN       (XLEN),
    .EARLY_TERM (EARLY_TERM)
  ) u_dp (
    .clk      (clk),
    .reset    (reset),
    .load_i   (accept),
    .step_i   (step),
    .a_i      (bus.a_i),
    .b_i      (bus.b_i),
    .signed_i (bus.signed_i),
    .last_o   (last),
    .result_o (result)
  );

  always_comb begin
    state_d   = state_q;
    product_d = product_q;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = OPERATE;
      end
      OPERATE: begin
        step = 1'b1;
        if (last) begin
          state_d   = DONE;
          product_d = result;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      product_q <= product_d;
    end
  end

endmodule
